// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset core (FSM controller + shared ALU)
// with a single unified instruction/data memory port using a req/ready handshake.
// Optional feature macro: MIPS_MC_BNE_EN (adds bne, opcode 05, as a BRANCH variant).
//
// Handshake: mem_req is a Moore decode of the FSM state and stays high, with
// mem_addr/mem_we/mem_wdata held constant, until a cycle in which mem_ready=1;
// the transfer completes on that rising edge. mem_ready is ignored when
// mem_req=0. Read data is sampled on the completing edge.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        retire,
  output logic        trap,
  output logic [3:0]  dbg_state
);

  localparam int RW = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'h05;
`endif

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] rf_q [NREGS];

  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;

  // Instruction fields, always taken from the latched IR
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic [RW-1:0] rs_idx, rt_idx, rd_idx;
  logic [31:0]   signimm;
  logic [31:0]   rs_val, rt_val;
  logic [31:0]   alu_result;
  logic          funct_ok;
  logic          br_take;

  assign opcode  = ir_q[31:26];
  assign funct   = ir_q[5:0];
  assign rs_idx  = ir_q[21 +: RW];
  assign rt_idx  = ir_q[16 +: RW];
  assign rd_idx  = ir_q[11 +: RW];
  assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};

  // Register 0 always reads as zero
  assign rs_val = (rs_idx == '0) ? 32'h0 : rf_q[rs_idx];
  assign rt_val = (rt_idx == '0) ? 32'h0 : rf_q[rt_idx];

`ifdef MIPS_MC_BNE_EN
  assign br_take = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
  assign br_take = (a_q == b_q);
`endif

  // R-type ALU: wraps on overflow, slt is a signed compare
  always_comb begin
    alu_result = 32'h0;
    funct_ok   = 1'b1;
    case (funct)
      FN_ADD:  alu_result = a_q + b_q;
      FN_SUB:  alu_result = a_q - b_q;
      FN_AND:  alu_result = a_q & b_q;
      FN_OR:   alu_result = a_q | b_q;
      FN_SLT:  alu_result = {31'h0, ($signed(a_q) < $signed(b_q))};
      default: funct_ok   = 1'b0;
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = rt_idx;
    rf_wdata = alu_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rs_val;
        b_d   = rt_val;
        // Branch target precomputed while the ALU is otherwise idle
        alu_d = pc_q + {signimm[29:0], 2'b00};
        case (opcode)
          OP_RTYPE: state_d = funct_ok ? S_EXEC : S_TRAP;
          OP_LW:    state_d = S_MEMADR;
          OP_SW:    state_d = S_MEMADR;
          OP_BEQ:   state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
          OP_BNE:   state_d = S_BRANCH;
`endif
          OP_ADDI:  state_d = S_ADDIEX;
          OP_J:     state_d = S_JUMP;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_d   = a_q + signimm;
        state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt_idx;
        rf_wdata = mdr_q;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_d   = alu_result;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we    = 1'b1;
        rf_waddr = rd_idx;
        rf_wdata = alu_q;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_d   = a_q + signimm;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we    = 1'b1;
        rf_waddr = rt_idx;
        rf_wdata = alu_q;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        if (br_take) pc_d = alu_q;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // State, datapath and register file storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      alu_q   <= 32'h0;
      mdr_q   <= 32'h0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // Moore memory-port decodes; gating with reset drops a pending request at once
  always_comb begin
    mem_req   = reset & ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR));
    mem_we    = reset & (state_q == S_MEMWR);
    mem_addr  = (state_q == S_FETCH) ? pc_q : alu_q;
    mem_wdata = b_q;
  end

  // Retire pulses in the last cycle of each instruction; sw retires on its completing cycle
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  assign trap      = (state_q == S_TRAP);
  assign pc        = pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs run from a bench-side unified memory.
// Every completed memory transaction (fetch, load, store) is checked in order
// against an expected queue filled by each test before reset release.
module tb_mips_multicycle_core;

  localparam logic [31:0] HALT = 32'hFC00_0000;  // opcode 3F: illegal, traps

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready = 1'b1;
  logic [31:0] pc;
  logic        retire, trap;
  logic [3:0]  dbg_state;

  logic [31:0] mem [0:511];
  logic [64:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;
  int cycle_cnt = 0;
  int first_ret_cycle = 0;
  int retire_cnt = 0;
  logic [31:0] first_ret_pc = 32'h0;
  int ready_mode = 0;  // 0: always ready, 1: random waits, 2: held by test
  logic        pend = 1'b0;
  logic [64:0] pend_txn = '0;
  logic [64:0] cur_txn, exp_txn;

  mips_multicycle_core #(.RESET_PC(32'h0), .NREGS(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc        (pc),
    .retire    (retire),
    .trap      (trap),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[10:2]];

  // Encoders
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic exp_rd(input logic [31:0] addr);
    exp_q.push_back({1'b0, addr, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({1'b1, addr, data});
  endtask

  // Ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 1) mem_ready = ($urandom_range(0, 2) != 0);
      else if (ready_mode == 0) mem_ready = 1'b1;
    end
  end

  // Monitor / scoreboard: request stability, transaction order, retire tracking
  always @(negedge clk) begin
    if (!reset) begin
      pend = 1'b0;
    end else begin
      cycle_cnt++;
      if (retire) begin
        retire_cnt++;
        if (first_ret_cycle == 0) begin
          first_ret_cycle = cycle_cnt;
          first_ret_pc    = pc;
        end
      end
      cur_txn = {mem_we, mem_addr, (mem_we ? mem_wdata : 32'h0)};
      if (pend && mem_req) check("req_stable", cur_txn, pend_txn);
      if (mem_req && mem_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_txn: got %h expected none", cur_txn);
        end else begin
          exp_txn = exp_q.pop_front();
          check("mem_txn", cur_txn, exp_txn);
        end
        if (mem_we) mem[mem_addr[10:2]] = mem_wdata;
        pend = 1'b0;
      end else begin
        pend = mem_req;
      end
      pend_txn = cur_txn;
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    reset      = 1'b0;
    ready_mode = 0;
    mem_ready  = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = HALT;
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    cycle_cnt       = 0;
    first_ret_cycle = 0;
    retire_cnt      = 0;
    pend            = 1'b0;
    reset           = 1'b1;
  endtask

  task automatic wait_trap(input string name, input int exp_retires);
    int n;
    n = 0;
    while (!trap && n < 400) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({name, "_trap"}, trap, 1);
    repeat (4) @(negedge clk);
    #1;
    check({name, "_queue_drained"}, exp_q.size(), 0);
    check({name, "_no_req_in_trap"}, mem_req, 0);
    check({name, "_trap_sticky"}, trap, 1);
    check({name, "_retire_count"}, retire_cnt, exp_retires);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 512; i++) mem[i] = HALT;

    // Reset state
    hold_reset();
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_retire", retire, 0);
    check("rst_trap", trap, 0);
    check("rst_pc", pc, 32'h0);

    // A: addi $1,$0,5 ; sw $1,0x80($0)
    mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = i_ins(6'h2B, 5'd0, 5'd1, 16'h0080);
    exp_rd(32'h0); exp_rd(32'h4); exp_wr(32'h80, 32'h5); exp_rd(32'h8);
    release_reset();
    @(negedge clk);
    #1;
    check("A_req_cycle1", mem_req, 1);
    check("A_addr_cycle1", mem_addr, 32'h0);
    wait_trap("A", 2);
    check("A_addi_retire_cycle", first_ret_cycle, 4);
    check("A_pc_at_retire", first_ret_pc, 32'h4);

    // B: fetch of lw stalled 3 cycles
    hold_reset();
    mem[0] = i_ins(6'h23, 5'd0, 5'd2, 16'h0008);
    mem[1] = i_ins(6'h2B, 5'd0, 5'd2, 16'h0084);
    mem[2] = 32'hDEAD_BEEF;
    exp_rd(32'h0); exp_rd(32'h8); exp_rd(32'h4); exp_wr(32'h84, 32'hDEAD_BEEF); exp_rd(32'h8);
    ready_mode = 2;
    mem_ready  = 1'b0;
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    mem_ready  = 1'b1;
    ready_mode = 0;
    wait_trap("B", 2);
    check("B_lw_retire_cycle", first_ret_cycle, 8);

    // C: beq taken at 0x10, not taken at 0x1C
    hold_reset();
    mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd7);
    mem[1] = i_ins(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = i_ins(6'h08, 5'd0, 5'd4, 16'd6);
    mem[3] = i_ins(6'h08, 5'd0, 5'd5, 16'h0055);
    mem[4] = i_ins(6'h04, 5'd1, 5'd2, 16'd2);
    mem[7] = i_ins(6'h04, 5'd1, 5'd4, 16'd2);
    mem[8] = i_ins(6'h2B, 5'd0, 5'd5, 16'h00A0);
    exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h8); exp_rd(32'hC); exp_rd(32'h10);
    exp_rd(32'h1C); exp_rd(32'h20); exp_wr(32'hA0, 32'h55); exp_rd(32'h24);
    release_reset();
    wait_trap("C", 7);

    // D: R-type ALU ops with random wait states
    hold_reset();
    mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'hFFFF);
    mem[1]  = i_ins(6'h08, 5'd0, 5'd2, 16'd1);
    mem[2]  = r_ins(5'd1, 5'd2, 5'd3, 6'h2A);
    mem[3]  = r_ins(5'd1, 5'd1, 5'd0, 6'h20);
    mem[4]  = r_ins(5'd2, 5'd1, 5'd4, 6'h22);
    mem[5]  = r_ins(5'd1, 5'd2, 5'd5, 6'h24);
    mem[6]  = r_ins(5'd2, 5'd4, 5'd6, 6'h25);
    mem[7]  = r_ins(5'd2, 5'd1, 5'd7, 6'h2A);
    mem[8]  = r_ins(5'd1, 5'd1, 5'd8, 6'h20);
    mem[9]  = i_ins(6'h2B, 5'd0, 5'd3, 16'h0100);
    mem[10] = i_ins(6'h2B, 5'd0, 5'd0, 16'h0104);
    mem[11] = i_ins(6'h2B, 5'd0, 5'd4, 16'h0108);
    mem[12] = i_ins(6'h2B, 5'd0, 5'd5, 16'h010C);
    mem[13] = i_ins(6'h2B, 5'd0, 5'd6, 16'h0110);
    mem[14] = i_ins(6'h2B, 5'd0, 5'd7, 16'h0114);
    mem[15] = i_ins(6'h2B, 5'd0, 5'd8, 16'h0118);
    for (int i = 0; i < 9; i++) exp_rd(32'(i * 4));
    exp_rd(32'h24); exp_wr(32'h100, 32'h1);
    exp_rd(32'h28); exp_wr(32'h104, 32'h0);
    exp_rd(32'h2C); exp_wr(32'h108, 32'h2);
    exp_rd(32'h30); exp_wr(32'h10C, 32'h1);
    exp_rd(32'h34); exp_wr(32'h110, 32'h3);
    exp_rd(32'h38); exp_wr(32'h114, 32'h0);
    exp_rd(32'h3C); exp_wr(32'h118, 32'hFFFF_FFFE);
    exp_rd(32'h40);
    ready_mode = 1;
    release_reset();
    wait_trap("D", 16);
    ready_mode = 0;

    // E: j 0x10 at 0, j 0x100 at 0x40
    hold_reset();
    mem[0]  = j_ins(26'h10);
    mem[16] = j_ins(26'h100);
    exp_rd(32'h0); exp_rd(32'h40); exp_rd(32'h400);
    release_reset();
    wait_trap("E", 2);
    check("E_j_retire_cycle", first_ret_cycle, 3);

    // F: unsupported funct traps
    hold_reset();
    mem[0] = r_ins(5'd1, 5'd2, 5'd3, 6'h21);
    exp_rd(32'h0);
    release_reset();
    wait_trap("F", 0);

`ifdef MIPS_MC_BNE_EN
    // G: bne $1,$2,-1 loops on itself
    hold_reset();
    mem[0] = i_ins(6'h08, 5'd0, 5'd1, 16'd1);
    mem[1] = i_ins(6'h05, 5'd1, 5'd2, 16'hFFFF);
    exp_rd(32'h0); exp_rd(32'h4); exp_rd(32'h4); exp_rd(32'h4);
    release_reset();
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    reset = 1'b0;
    check("G_bne_loop_fetches", exp_q.size(), 0);
    check("G_no_trap", trap, 0);
`else
    // G: opcode 05 is unsupported in this build
    hold_reset();
    mem[0] = i_ins(6'h05, 5'd1, 5'd2, 16'hFFFF);
    exp_rd(32'h0);
    release_reset();
    wait_trap("G", 0);
`endif

    // H: reset asserted while a store is waiting
    hold_reset();
    mem[0]  = i_ins(6'h08, 5'd0, 5'd1, 16'd9);
    mem[1]  = i_ins(6'h2B, 5'd0, 5'd1, 16'h0090);
    mem[36] = 32'h0000_1234;
    exp_rd(32'h0); exp_rd(32'h4);
    release_reset();
    repeat (7) @(posedge clk);
    #1;
    ready_mode = 2;
    mem_ready  = 1'b0;
    @(negedge clk);
    #1;
    check("H_memwr_req", mem_req, 1);
    check("H_memwr_we", mem_we, 1);
    check("H_memwr_addr", mem_addr, 32'h90);
    check("H_memwr_wdata", mem_wdata, 32'h9);
    reset = 1'b0;
    #1;
    check("H_req_drop", mem_req, 0);
    check("H_we_drop", mem_we, 0);
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("H_mem_unchanged", mem[36], 32'h0000_1234);
    check("H_queue_drained", exp_q.size(), 0);
    check("H_pc_reset", pc, 32'h0);
    ready_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
